// File: rtl/axis_burst_m_pkg.sv
// Shared types and width helpers for the axis_burst_m burst master and its FIFO.
package axis_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    DONE = 2'd2
  } axis_m_state_t;

  localparam int DEF_DATA_W  = 32;
  localparam int DEF_DEPTH   = 16;
  localparam int DEF_MAX_LEN = 256;

  // Pointer width into a FIFO of the given depth (at least one bit).
  function automatic int ptr_w(input int depth);
    return (depth < 2) ? 1 : $clog2(depth);
  endfunction

  // Occupancy width: must represent 0..depth inclusive.
  function automatic int lvl_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

  // Width of the burst-length field (beats minus one).
  function automatic int len_w(input int max_len);
    return (max_len < 2) ? 1 : $clog2(max_len);
  endfunction

endpackage

// File: rtl/axis_burst_m_if.sv
// Write-port and AXI-Stream signal bundle for axis_burst_m.
// Optional tuser sideband is present when AXIS_BURST_M_TUSER_EN is defined.
interface axis_burst_m_if #(
  parameter int DATA_W = 32
) ();
  logic              wr_valid;
  logic              wr_ready;
  logic [DATA_W-1:0] wr_data;
  logic              tvalid;
  logic              tready;
  logic              tlast;
  logic [DATA_W-1:0] tdata;
`ifdef AXIS_BURST_M_TUSER_EN
  logic              tuser;
`endif

  modport master (
    input  wr_valid, wr_data, tready,
    output wr_ready, tvalid, tlast, tdata
`ifdef AXIS_BURST_M_TUSER_EN
    , output tuser
`endif
  );

  modport slave (
    output wr_valid, wr_data, tready,
    input  wr_ready, tvalid, tlast, tdata
`ifdef AXIS_BURST_M_TUSER_EN
    , input tuser
`endif
  );
endinterface

// File: rtl/axis_burst_m_sync_fifo.sv
// First-word-fall-through synchronous FIFO; head word is presented combinationally.
module axis_sync_fifo
  import axis_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      wr_req,
  input  logic [DATA_W-1:0]         wr_data,
  input  logic                      rd_req,
  output logic                      full,
  output logic                      empty,
  output logic [lvl_w(DEPTH)-1:0]   level,
  output logic [DATA_W-1:0]         rd_data
);
  localparam int AW = ptr_w(DEPTH);
  localparam int LW = lvl_w(DEPTH);

  logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]     count_q, count_d;
  logic [DATA_W-1:0] mem_q [DEPTH];
  logic              push, pop;

  assign full    = (count_q == LW'(DEPTH));
  assign empty   = (count_q == '0);
  assign level   = count_q;
  assign rd_data = mem_q[rd_ptr_q];

  // A full FIFO refuses writes even when a pop frees a slot in the same cycle.
  assign push = wr_req && !full;
  assign pop  = rd_req && !empty;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
    case ({push, pop})
      2'b10:   count_d = count_q + LW'(1);
      2'b01:   count_d = count_q - LW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage is data only: never reset, written on accepted pushes.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= wr_data;
  end

endmodule

// File: rtl/axis_burst_m.sv
// AXI-Stream burst master: buffers local writes and emits length-programmed bursts.
// Define AXIS_BURST_M_TUSER_EN to add a first-beat tuser marker.
module axis_burst_m
  import axis_pkg::*;
#(
  parameter int DATA_W  = 32,
  parameter int DEPTH   = 16,
  parameter int MAX_LEN = 256
) (
  input  logic                      aclk,
  input  logic                      areset,
  axis_burst_m_if.master            bus,
  input  logic                      send,
  input  logic [len_w(MAX_LEN)-1:0] len,
  output logic                      busy,
  output logic [lvl_w(DEPTH)-1:0]   level,
  output logic                      finish
);
  localparam int LEN_W = len_w(MAX_LEN);

  axis_m_state_t     state_q, state_d;
  logic [LEN_W-1:0]  rem_q, rem_d;
  logic              full, empty, tvalid, pop;
  logic [DATA_W-1:0] head;

  axis_sync_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_fifo (
    .clk     (aclk),
    .rst     (areset),
    .wr_req  (bus.wr_valid),
    .wr_data (bus.wr_data),
    .rd_req  (pop),
    .full    (full),
    .empty   (empty),
    .level   (level),
    .rd_data (head)
  );

  // tvalid only falls through a pop, so the head word stays stable under backpressure.
  assign tvalid       = (state_q == SEND) && !empty;
  assign pop          = tvalid && bus.tready;
  assign bus.tvalid   = tvalid;
  assign bus.tdata    = head;
  assign bus.tlast    = tvalid && (rem_q == '0);
  assign bus.wr_ready = !full;
  assign busy         = (state_q != IDLE);
  assign finish       = (state_q == DONE);

  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    case (state_q)
      IDLE: begin
        if (send) begin
          state_d = SEND;
          rem_d   = len;
        end
      end
      SEND: begin
        if (pop) begin
          if (rem_q == '0) state_d = DONE;
          else             rem_d   = rem_q - LEN_W'(1);
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      state_q <= IDLE;
      rem_q   <= '0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
    end
  end

`ifdef AXIS_BURST_M_TUSER_EN
  logic [LEN_W-1:0] len_q, len_d;

  // First beat is the one where nothing has been counted off yet.
  assign bus.tuser = tvalid && (rem_q == len_q);

  always_comb begin
    len_d = len_q;
    if (state_q == IDLE && send) len_d = len;
  end

  always_ff @(posedge aclk) begin
    if (areset) len_q <= '0;
    else        len_q <= len_d;
  end
`endif

endmodule
